// File: rtl/pentarv_mem_pkg.sv
// Shared encodings for the data-memory responder: funct3 access sizes,
// responder FSM states and the wait-state counter width.
package pentarv_mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DUMP = 2'd3
    } state_t;

    function automatic logic size_legal(input logic [2:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) ||
               (sz == SZ_BU) || (sz == SZ_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store lane enables and replicated write
// word, load lane extraction with sign/zero extension, and misalignment flag.
module dmem_lane_align
    import pentarv_mem_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte     = i_rword[{i_addr_lo, 3'b000} +: 8];
        w_half     = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_be       = 4'b0000;
        o_wword    = i_wdata;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_size)
            SZ_B, SZ_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = i_size[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_H, SZ_HU: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword    = {2{i_wdata[15:0]}};
                o_rdata    = i_size[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            SZ_W: begin
                o_be       = 4'b1111;
                o_rdata    = i_rword;
                o_misalign = |i_addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: valid/ready requests with programmable wait states,
// sized loads/stores with error reporting, and a whole-array dump engine.
module dmem_responder
    import pentarv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        dump,
    output logic        dump_valid,
    output logic [31:0] dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_done,
    output logic        busy
);

    localparam int             IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W:0] IDX_END = (IDX_W + 1)'(DEPTH_WORDS);

    state_t           r_state;
    logic [LAT_W-1:0] r_cnt;
    logic             r_dump_pend;
    logic             r_we;
    logic [2:0]       r_size;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [IDX_W:0]   r_idx;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;
    logic             r_dump_valid;
    logic [31:0]      r_dump_addr;
    logic [31:0]      r_dump_data;
    logic             r_dump_done;

    logic [IDX_W-1:0] w_widx;
    logic [31:0]      w_rword;
    logic [3:0]       w_be;
    logic [31:0]      w_wword;
    logic [31:0]      w_rdata;
    logic             w_misalign;
    logic             w_range_err;
    logic             w_err;
    logic             w_access;
    logic             w_mem_wr;

    assign w_widx      = r_addr[IDX_W+1:2];
    assign w_rword     = r_mem[w_widx];
    assign w_range_err = (r_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err       = w_misalign || w_range_err || (r_we && r_size[2]) || !size_legal(r_size);
    assign w_access    = (r_state == WAIT) && (r_cnt == '0);
    assign w_mem_wr    = w_access && r_we && !w_err;

    dmem_lane_align u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign)
    );

    // Array has no reset; a store only lands on the final wait-state edge.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_dump_pend  <= 1'b0;
            r_we         <= 1'b0;
            r_size       <= 3'b000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_idx        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 32'h0;
            r_rsp_err    <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= 32'h0;
            r_dump_data  <= 32'h0;
            r_dump_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dump || r_dump_pend) begin
                        r_state      <= DUMP;
                        r_dump_pend  <= 1'b0;
                        r_dump_valid <= 1'b1;
                        r_dump_addr  <= 32'h0;
                        r_dump_data  <= r_mem[0];
                        r_idx        <= (IDX_W + 1)'(1);
                    end else if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= LAT_W'(LATENCY);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dump) r_dump_pend <= 1'b1;
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_we) ? 32'h0 : w_rdata;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (dump) r_dump_pend <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                    r_state     <= IDLE;
                end
                DUMP: begin
                    // Words 0..N-1, then a done cycle, then back to IDLE.
                    if (r_dump_done) begin
                        r_dump_done <= 1'b0;
                        r_state     <= IDLE;
                    end else if (r_idx == IDX_END) begin
                        r_dump_valid <= 1'b0;
                        r_dump_addr  <= 32'h0;
                        r_dump_data  <= 32'h0;
                        r_dump_done  <= 1'b1;
                    end else begin
                        r_dump_addr <= 32'({r_idx, 2'b00});
                        r_dump_data <= r_mem[r_idx[IDX_W-1:0]];
                        r_idx       <= r_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE) && !dump && !r_dump_pend;
    assign busy       = (r_state != IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign dump_done  = r_dump_done;

endmodule
